// File: rtl/lockstep_cmp.sv
// lockstep_cmp: compares a reference bus (a_in) against a checked bus (b_in),
// channel by channel, after delaying the reference side by SKEW cycles.
// Mismatches are reported per channel, latched into a sticky error flag,
// counted (saturating at 255) and escalated to an alarm at ERR_MAX.
//
// Ports:
//   clk       sole clock, rising edge
//   rst       asynchronous active-high reset
//   en        compare enable; dropping it parks the FSM in IDLE
//   clr       synchronous clear of err, err_cnt, first_ch, alarm
//   a_in      reference side, channel k at [k*WIDTH +: WIDTH]
//   b_in      checked side, same packing
//   mismatch  registered per-channel result of the last valid compare
//   err       sticky error flag
//   err_cnt   saturating count of cycles with at least one mismatch
//   first_ch  lowest mismatching channel of the first error since clear
//   alarm     registered (err_cnt >= ERR_MAX)
module lockstep_cmp #(
    parameter int CH      = 2,
    parameter int WIDTH   = 1,
    parameter int SKEW    = 0,
    parameter int ERR_MAX = 15
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  en,
    input  logic                                  clr,
    input  logic [CH*WIDTH-1:0]                   a_in,
    input  logic [CH*WIDTH-1:0]                   b_in,
    output logic [CH-1:0]                         mismatch,
    output logic                                  err,
    output logic [7:0]                            err_cnt,
    output logic [((CH > 1) ? $clog2(CH) : 1)-1:0] first_ch,
    output logic                                  alarm
);

    localparam int FW = (CH > 1) ? $clog2(CH) : 1;
    // Last warm-up count value; only meaningful when SKEW > 0.
    localparam logic [2:0] WARM_LAST = (SKEW > 0) ? 3'(SKEW - 1) : 3'd0;
    localparam logic [7:0] ERR_MAX_C = 8'(ERR_MAX);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WARMUP = 2'd1,
        CHECK  = 2'd2,
        FAULT  = 2'd3
    } state_t;

    state_t          state_r, state_nxt_s;
    logic [2:0]      warm_r, warm_nxt_s;
    logic [CH-1:0]   mm_r, mm_nxt_s, mm_s;
    logic            err_r, err_nxt_s;
    logic [7:0]      cnt_r, cnt_nxt_s, cnt_inc_s;
    logic [FW-1:0]   first_r, first_nxt_s, low_s;
    logic            alarm_r;
    logic            any_s, valid_s;
    logic [CH*WIDTH-1:0] a_dly_s;

    generate
        if (SKEW == 0) begin : g_nodly
            assign a_dly_s = a_in;
        end else begin : g_dly
            logic [CH*WIDTH-1:0] dly_r [SKEW];

            // Reference delay line; shifts every cycle, independent of en.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    for (int i = 0; i < SKEW; i++) dly_r[i] <= '0;
                end else begin
                    dly_r[0] <= a_in;
                    for (int i = 1; i < SKEW; i++) dly_r[i] <= dly_r[i-1];
                end
            end

            assign a_dly_s = dly_r[SKEW-1];
        end
    endgenerate

    // Per-channel compare and lowest-index priority encode of the result.
    always_comb begin
        mm_s  = '0;
        low_s = '0;
        for (int k = 0; k < CH; k++) begin
            mm_s[k] = (a_dly_s[k*WIDTH +: WIDTH] != b_in[k*WIDTH +: WIDTH]);
        end
        // Scan downward so the lowest mismatching index is the one kept.
        for (int k = CH - 1; k >= 0; k--) begin
            low_s = mm_s[k] ? FW'(k) : low_s;
        end
    end

    assign any_s     = |mm_s;
    assign valid_s   = en && ((state_r == CHECK) || (state_r == FAULT));
    assign cnt_inc_s = (cnt_r == 8'hFF) ? 8'hFF : (cnt_r + 8'd1);

    // FSM next-state and warm-up counter.
    always_comb begin
        state_nxt_s = state_r;
        warm_nxt_s  = warm_r;
        if (!en) begin
            state_nxt_s = IDLE;
            warm_nxt_s  = 3'd0;
        end else begin
            case (state_r)
                IDLE: begin
                    warm_nxt_s  = 3'd0;
                    state_nxt_s = (SKEW > 0) ? WARMUP : CHECK;
                end
                WARMUP: begin
                    warm_nxt_s  = warm_r + 3'd1;
                    state_nxt_s = (warm_r == WARM_LAST) ? CHECK : WARMUP;
                end
                CHECK: begin
                    state_nxt_s = any_s ? FAULT : CHECK;
                end
                FAULT: begin
                    // A fresh mismatch outranks clr.
                    if (any_s) begin
                        state_nxt_s = FAULT;
                    end else if (clr) begin
                        state_nxt_s = CHECK;
                    end else begin
                        state_nxt_s = FAULT;
                    end
                end
                default: begin
                    state_nxt_s = IDLE;
                    warm_nxt_s  = 3'd0;
                end
            endcase
        end
    end

    // Error bookkeeping: mismatch bits, sticky flag, counter, first channel.
    always_comb begin
        mm_nxt_s    = valid_s ? mm_s : '0;
        err_nxt_s   = err_r;
        cnt_nxt_s   = cnt_r;
        first_nxt_s = first_r;
        if (valid_s && any_s) begin
            err_nxt_s = 1'b1;
            if (clr) begin
                // Clear and new error together: restart the record from this error.
                cnt_nxt_s   = 8'd1;
                first_nxt_s = low_s;
            end else begin
                cnt_nxt_s   = cnt_inc_s;
                first_nxt_s = err_r ? first_r : low_s;
            end
        end else if (clr) begin
            err_nxt_s   = 1'b0;
            cnt_nxt_s   = 8'd0;
            first_nxt_s = '0;
        end else begin
            err_nxt_s   = err_r;
            cnt_nxt_s   = cnt_r;
            first_nxt_s = first_r;
        end
    end

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
            warm_r  <= 3'd0;
            mm_r    <= '0;
            err_r   <= 1'b0;
            cnt_r   <= 8'd0;
            first_r <= '0;
            alarm_r <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            warm_r  <= warm_nxt_s;
            mm_r    <= mm_nxt_s;
            err_r   <= err_nxt_s;
            cnt_r   <= cnt_nxt_s;
            first_r <= first_nxt_s;
            // Built from the next count so alarm rises with err_cnt itself.
            alarm_r <= (cnt_nxt_s >= ERR_MAX_C);
        end
    end

    assign mismatch = mm_r;
    assign err      = err_r;
    assign err_cnt  = cnt_r;
    assign first_ch = first_r;
    assign alarm    = alarm_r;

endmodule

// File: tb/tb_lockstep_cmp.sv
// Directed self-checking bench for lockstep_cmp; four instances cover the
// SKEW=0 narrow/wide cases, a SKEW=3 delay-matched stream and a SKEW=2
// mid-run reset.
module tb_lockstep_cmp;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rst3 = 1'b1;

    int n_checks = 0;
    int n_errors = 0;

    // u0: CH=2, WIDTH=1, SKEW=0
    logic       en0 = 1'b0, clr0 = 1'b0;
    logic [1:0] a0 = 2'd0, b0 = 2'd0, mm0;
    logic       err0, fc0, al0;
    logic [7:0] cnt0;

    // u1: CH=4, WIDTH=8, SKEW=0, ERR_MAX=4
    logic        en1 = 1'b0, clr1 = 1'b0;
    logic [31:0] a1 = 32'd0, b1 = 32'd0;
    logic [3:0]  mm1;
    logic        err1, al1;
    logic [7:0]  cnt1;
    logic [1:0]  fc1;

    // u2: CH=2, WIDTH=4, SKEW=3
    logic       en2 = 1'b0, clr2 = 1'b0;
    logic [7:0] a2 = 8'd0, b2 = 8'd0;
    logic [1:0] mm2;
    logic       err2, fc2, al2;
    logic [7:0] cnt2;
    logic [7:0] h [3];

    // u3: CH=2, WIDTH=4, SKEW=2
    logic       en3 = 1'b0, clr3 = 1'b0;
    logic [7:0] a3 = 8'h55, b3 = 8'h55;
    logic [1:0] mm3;
    logic       err3, fc3, al3;
    logic [7:0] cnt3;

    lockstep_cmp #(.CH(2), .WIDTH(1), .SKEW(0), .ERR_MAX(15)) u0 (
        .clk(clk), .rst(rst), .en(en0), .clr(clr0), .a_in(a0), .b_in(b0),
        .mismatch(mm0), .err(err0), .err_cnt(cnt0), .first_ch(fc0), .alarm(al0));

    lockstep_cmp #(.CH(4), .WIDTH(8), .SKEW(0), .ERR_MAX(4)) u1 (
        .clk(clk), .rst(rst), .en(en1), .clr(clr1), .a_in(a1), .b_in(b1),
        .mismatch(mm1), .err(err1), .err_cnt(cnt1), .first_ch(fc1), .alarm(al1));

    lockstep_cmp #(.CH(2), .WIDTH(4), .SKEW(3), .ERR_MAX(15)) u2 (
        .clk(clk), .rst(rst), .en(en2), .clr(clr2), .a_in(a2), .b_in(b2),
        .mismatch(mm2), .err(err2), .err_cnt(cnt2), .first_ch(fc2), .alarm(al2));

    lockstep_cmp #(.CH(2), .WIDTH(4), .SKEW(2), .ERR_MAX(15)) u3 (
        .clk(clk), .rst(rst3), .en(en3), .clr(clr3), .a_in(a3), .b_in(b3),
        .mismatch(mm3), .err(err3), .err_cnt(cnt3), .first_ch(fc3), .alarm(al3));

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drive a fresh reference word and b = reference from 3 cycles ago ^ flip.
    task automatic step2(input logic [7:0] flip);
        a2 = 8'($urandom_range(0, 255));
        b2 = h[2] ^ flip;
        step();
        h[2] = h[1];
        h[1] = h[0];
        h[0] = a2;
    endtask

    initial begin
        int exp_cnt;
        h[0] = 8'd0; h[1] = 8'd0; h[2] = 8'd0;

        // Reset state, asynchronous, before any clock edge
        #1;
        check_eq("rst_mm",    32'(mm1),  32'd0);
        check_eq("rst_err",   32'(err1), 32'd0);
        check_eq("rst_cnt",   32'(cnt1), 32'd0);
        check_eq("rst_fc",    32'(fc1),  32'd0);
        check_eq("rst_alarm", 32'(al1),  32'd0);
        step();
        step();
        rst  = 1'b0;
        rst3 = 1'b0;

        // u0: matching inputs for 20 cycles
        en0 = 1'b1;
        for (int i = 0; i < 20; i++) begin
            a0 = 2'($urandom_range(0, 3));
            b0 = a0;
            step();
            check_eq("u0_mm",  32'(mm0),  32'd0);
            check_eq("u0_err", 32'(err0), 32'd0);
            check_eq("u0_cnt", 32'(cnt0), 32'd0);
        end
        en0 = 1'b0;

        // u1: channels 1 and 3 differ
        a1 = 32'hA0B0_C0D0;
        b1 = a1;
        en1 = 1'b1;
        step();
        step();
        check_eq("u1_eq_mm",  32'(mm1),  32'd0);
        check_eq("u1_eq_err", 32'(err1), 32'd0);
        b1 = a1 ^ 32'h0100_0100;
        step();
        check_eq("u1_mm13",  32'(mm1),  32'b1010);
        check_eq("u1_err",   32'(err1), 32'd1);
        check_eq("u1_cnt1",  32'(cnt1), 32'd1);
        check_eq("u1_fc1",   32'(fc1),  32'd1);
        check_eq("u1_al0",   32'(al1),  32'd0);
        for (int i = 2; i <= 7; i++) begin
            step();
            check_eq("u1_cnt_up", 32'(cnt1), 32'(i));
            check_eq("u1_alarm",  32'(al1),  (i >= 4) ? 32'd1 : 32'd0);
            check_eq("u1_fc_hold", 32'(fc1), 32'd1);
        end

        // clr together with a channel 2 mismatch at err_cnt=7
        b1 = a1 ^ 32'h0001_0000;
        clr1 = 1'b1;
        step();
        clr1 = 1'b0;
        check_eq("clrmm_err", 32'(err1), 32'd1);
        check_eq("clrmm_cnt", 32'(cnt1), 32'd1);
        check_eq("clrmm_fc",  32'(fc1),  32'd2);
        check_eq("clrmm_mm",  32'(mm1),  32'b0100);
        check_eq("clrmm_al",  32'(al1),  32'd0);

        // 300 consecutive mismatching cycles: alarm at 4, saturation at 255
        for (int i = 0; i < 300; i++) begin
            step();
            exp_cnt = (i + 2 > 255) ? 255 : i + 2;
            check_eq("sat_cnt",   32'(cnt1), 32'(exp_cnt));
            check_eq("sat_alarm", 32'(al1),  (exp_cnt >= 4) ? 32'd1 : 32'd0);
        end

        // clr alone
        b1 = a1;
        clr1 = 1'b1;
        step();
        clr1 = 1'b0;
        check_eq("clr_cnt", 32'(cnt1), 32'd0);
        check_eq("clr_al",  32'(al1),  32'd0);
        check_eq("clr_err", 32'(err1), 32'd0);
        check_eq("clr_fc",  32'(fc1),  32'd0);
        step();
        check_eq("chk_mm",  32'(mm1),  32'd0);
        b1 = a1 ^ 32'h0000_0001;
        step();
        check_eq("ch0_mm",  32'(mm1),  32'b0001);
        check_eq("ch0_cnt", 32'(cnt1), 32'd1);
        check_eq("ch0_fc",  32'(fc1),  32'd0);

        // en=0 retains error state and suppresses compares; re-entry restarts
        en1 = 1'b0;
        step();
        check_eq("dis_mm",  32'(mm1),  32'd0);
        check_eq("dis_err", 32'(err1), 32'd1);
        check_eq("dis_cnt", 32'(cnt1), 32'd1);
        step();
        check_eq("dis_cnt2", 32'(cnt1), 32'd1);
        en1 = 1'b1;
        step();
        check_eq("reen_mm",  32'(mm1),  32'd0);
        check_eq("reen_cnt", 32'(cnt1), 32'd1);
        b1 = a1 ^ 32'h0000_0100;
        step();
        check_eq("reen_mm2",  32'(mm1),  32'b0010);
        check_eq("reen_cnt2", 32'(cnt1), 32'd2);
        check_eq("reen_fc",   32'(fc1),  32'd0);
        en1 = 1'b0;

        // u2: SKEW=3, b follows delayed a; corrupted b during warm-up ignored
        for (int i = 0; i < 5; i++) begin
            step2(8'h00);
            check_eq("u2_pre_mm", 32'(mm2), 32'd0);
        end
        en2 = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step2(8'hFF);
            check_eq("u2_warm_mm",  32'(mm2),  32'd0);
            check_eq("u2_warm_err", 32'(err2), 32'd0);
        end
        for (int i = 0; i < 8; i++) begin
            step2(8'h00);
            check_eq("u2_run_mm",  32'(mm2),  32'd0);
            check_eq("u2_run_err", 32'(err2), 32'd0);
        end
        step2(8'h10);
        check_eq("u2_bad_mm",  32'(mm2),  32'b10);
        check_eq("u2_bad_err", 32'(err2), 32'd1);
        check_eq("u2_bad_fc",  32'(fc2),  32'd1);
        check_eq("u2_bad_cnt", 32'(cnt2), 32'd1);
        step2(8'h00);
        check_eq("u2_after_mm",  32'(mm2),  32'd0);
        check_eq("u2_after_err", 32'(err2), 32'd1);

        // u3: SKEW=2, error then asynchronous reset mid-run
        en3 = 1'b1;
        step();
        step();
        step();
        b3 = 8'h54;
        step();
        check_eq("u3_err_pre", 32'(err3), 32'd1);
        check_eq("u3_mm_pre",  32'(mm3),  32'b01);
        b3 = 8'h55;
        #3;
        rst3 = 1'b1;
        #1;
        check_eq("u3_rst_mm",  32'(mm3),  32'd0);
        check_eq("u3_rst_err", 32'(err3), 32'd0);
        check_eq("u3_rst_cnt", 32'(cnt3), 32'd0);
        check_eq("u3_rst_fc",  32'(fc3),  32'd0);
        check_eq("u3_rst_al",  32'(al3),  32'd0);
        step();
        rst3 = 1'b0;
        // Delay line restarts empty: the zero stages would mismatch if compared
        for (int i = 0; i < 4; i++) begin
            step();
            check_eq("u3_wu_mm",  32'(mm3),  32'd0);
            check_eq("u3_wu_err", 32'(err3), 32'd0);
        end
        b3 = 8'h57;
        step();
        check_eq("u3_live_mm",  32'(mm3),  32'b01);
        check_eq("u3_live_err", 32'(err3), 32'd1);
        check_eq("u3_live_fc",  32'(fc3),  32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/lockstep_cmp.md
LOCKSTEP_CMP -- requirements
Module: lockstep_cmp

Interface
REQ-001 Parameter CH, default 2: number of compared channels, 1..16.
REQ-002 Parameter WIDTH, default 1: bits per channel, 1..32.
REQ-003 Parameter SKEW, default 0: cycles by which side A is delayed before comparison, 0..7.
REQ-004 Parameter ERR_MAX, default 15: mismatch count at which alarm asserts, 1..255.
REQ-005 clk  in  1  sole clock; all state updates on posedge clk.
REQ-006 rst  in  1  reset, asynchronous, active-high.
REQ-007 en  in  1  compare enable.
REQ-008 clr  in  1  synchronous clear of err, err_cnt, first_ch, alarm.
REQ-009 a_in  in  CH*WIDTH  reference side; channel k occupies bits [k*WIDTH +: WIDTH].
REQ-010 b_in  in  CH*WIDTH  checked side, same packing.
REQ-011 mismatch  out  CH  registered per-channel result of the last valid compare.
REQ-012 err  out  1  sticky, set on any mismatch.
REQ-013 err_cnt  out  8  saturating count of cycles with at least one mismatch.
REQ-014 first_ch  out  max(1,$clog2(CH))  channel index of the first mismatch since the last clear.
REQ-015 alarm  out  1  high while err_cnt >= ERR_MAX.

Function
REQ-016 Side A SHALL pass through a SKEW-stage delay line that shifts every cycle regardless of en; SKEW=0 means no delay.
REQ-017 Channel k SHALL mismatch when delayed a_in channel k != b_in channel k (full WIDTH bits compared).
REQ-018 The FSM SHALL have the states IDLE, WARMUP, CHECK and FAULT.
REQ-019 In IDLE with en=1, the next state SHALL be WARMUP if SKEW>0, else CHECK; the warm-up counter loads 0.
REQ-020 WARMUP SHALL increment the warm-up counter each cycle and move to CHECK once the counter reaches SKEW-1, so that exactly SKEW cycles are suppressed.
REQ-021 Compares SHALL be valid only in CHECK and FAULT; in IDLE and WARMUP the mismatch output SHALL be 0 and err/err_cnt SHALL hold.
REQ-022 A valid compare with any channel mismatching SHALL, on the next edge, set the mismatch bits, set err, increment err_cnt (saturating at 255) and move to FAULT.
REQ-023 Latency: a_in sampled at edge t and b_in sampled at edge t+SKEW SHALL yield a mismatch/err update visible after edge t+SKEW+1.
REQ-024 first_ch SHALL load only when err is 0 before the edge; if several channels mismatch, it SHALL take the lowest index.
REQ-025 In FAULT the block SHALL keep comparing and counting; clr with no new mismatch SHALL return the FSM to CHECK.
REQ-026 clr together with a new mismatch in the same cycle SHALL be resolved with the mismatch winning: err=1, err_cnt=1, first_ch=new lowest index, FSM in FAULT.
REQ-027 en=0 in any state SHALL move the FSM to IDLE on the next edge; err, err_cnt and first_ch SHALL be retained.
REQ-028 Any re-entry from IDLE SHALL restart warm-up.
REQ-029 alarm SHALL be a registered copy of (err_cnt >= ERR_MAX) and SHALL assert in the same cycle err_cnt reaches ERR_MAX.

Reset
REQ-030 rst=1 SHALL asynchronously force the FSM to IDLE and set mismatch, err, err_cnt, first_ch, alarm, the warm-up counter and all delay-line stages to 0.
REQ-031 Reset mid-operation SHALL discard in-flight delayed data; after release, the first valid compare SHALL occur only after a full warm-up.

Verification
REQ-032 CH=2, WIDTH=1, SKEW=0; a_in=b_in for 20 cycles with en=1 -> err=0, err_cnt=0, mismatch=00 throughout.
REQ-033 CH=4, WIDTH=8, SKEW=0; one cycle with channels 1 and 3 differing -> one cycle later mismatch=1010, err=1, err_cnt=1, first_ch=1, FSM=FAULT.
REQ-034 SKEW=3; b_in equals a_in delayed by 3 cycles, after en rise -> no mismatch; corrupt one b_in sample -> err rises exactly 1 cycle later; the first 3 cycles after en rise are never flagged.
REQ-035 ERR_MAX=4; 300 consecutive mismatching cycles -> alarm high once err_cnt=4, err_cnt saturates at 255; clr alone -> err_cnt=0, alarm=0, FSM=CHECK.
REQ-036 clr asserted in the same cycle as a channel 2 mismatch while err_cnt=7 -> err=1, err_cnt=1, first_ch=2.
REQ-037 rst pulse mid-CHECK with SKEW=2 and err=1 -> all outputs 0 immediately (asynchronously); after release with en=1, 2 cycles of suppressed compares precede CHECK.
